// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encodings and width for the iterative divider
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // Shifted remainder is kept at WIDTH+1 bits so the compare never drops the carry;
  // the difference itself always fits WIDTH bits because rem < divisor on entry.
  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative unsigned restoring divider, one quotient bit per clock
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic [2*WIDTH-1:0] Q,
  output logic               QVALID,
  output logic               DIVZERO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [2*WIDTH-1:0] r_q;
  logic               r_busy;
  logic               r_qvalid;
  logic               r_divzero;

  logic [WIDTH-1:0]   w_rem_next;
  logic               w_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_q       <= '0;
      r_busy    <= 1'b0;
      r_qvalid  <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_count <= '0;
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_rem   <= '0;
            r_quo   <= '0;
            // A zero divisor skips iteration and publishes the saturated result at once.
            if (divisor == '0) begin
              r_q       <= {{WIDTH{1'b1}}, dividend};
              r_qvalid  <= 1'b1;
              r_divzero <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_DONE;
            end else begin
              r_qvalid  <= 1'b0;
              r_divzero <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_rem   <= w_rem_next;
          r_quo   <= {r_quo[WIDTH-2:0], w_qbit};
          r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
          r_count <= r_count + 1'b1;
          if (r_count == LAST) begin
            r_q      <= {r_quo[WIDTH-2:0], w_qbit, w_rem_next};
            r_qvalid <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign Q       = r_q;
  assign QVALID  = r_qvalid;
  assign DIVZERO = r_divzero;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed scoreboard bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic [31:0] Q;
  logic        QVALID;
  logic        DIVZERO;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic [31:0] last_q;

  div_unit #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .Q        (Q),
    .QVALID   (QVALID),
    .DIVZERO  (DIVZERO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one operation from a negedge, counts busy cycles and checks the popped result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_q,
                        input logic exp_dz, input int exp_busy, input int glitch,
                        input string tag);
    int          cnt;
    logic [31:0] exp;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(exp_q);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      if (cnt == 0) begin
        check({tag, "_qhold"}, Q, last_q);
        check({tag, "_qvalid_low"}, {31'd0, QVALID}, 32'd0);
      end
      if (cnt == glitch) begin
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd9;
      end else begin
        start = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, cnt, exp_busy);
    check({tag, "_qvalid"}, {31'd0, QVALID}, 32'd1);
    check({tag, "_divzero"}, {31'd0, DIVZERO}, {31'd0, exp_dz});
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 32'hDEAD_BEEF;
    check({tag, "_q"}, Q, exp);
    last_q = exp;
  endtask

  initial begin
    int          cnt;
    logic [31:0] exp;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_q   = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_qvalid", {31'd0, QVALID}, 32'd0);
    check("reset_divzero", {31'd0, DIVZERO}, 32'd0);
    check("reset_q", Q, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic latency and result, then DONE holds
    run_op(16'd100, 16'd7, 32'h000E_0002, 1'b0, 16, -1, "t1");
    repeat (5) @(negedge clk);
    check("t1_hold_qvalid", {31'd0, QVALID}, 32'd1);
    check("t1_hold_q", Q, 32'h000E_0002);

    // 2: extremes
    run_op(16'hFFFF, 16'd1, 32'hFFFF_0000, 1'b0, 16, -1, "t2a");
    run_op(16'd5, 16'd9, 32'h0000_0005, 1'b0, 16, -1, "t2b");

    // 3: divide by zero
    run_op(16'd1234, 16'd0, 32'hFFFF_04D2, 1'b1, 0, -1, "t3");

    // 4: start pulsed mid-run is ignored
    run_op(16'd200, 16'd3, 32'h0042_0002, 1'b0, 16, 4, "t4");

    // 5: async reset mid-operation
    start    = 1'b1;
    dividend = 16'd500;
    divisor  = 16'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_qvalid", {31'd0, QVALID}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_q", Q, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_post_qvalid", {31'd0, QVALID}, 32'd0);
    last_q = '0;
    run_op(16'd500, 16'd10, 32'h0032_0000, 1'b0, 16, -1, "t5");

    // 6: start held high across DONE gives a one-cycle QVALID and a back-to-back op
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd8;
    sb.push_back(32'h0006_0002);
    @(negedge clk);
    dividend = 16'd77;
    divisor  = 16'd7;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("t6a_busy_cycles", cnt, 32'd16);
    check("t6a_qvalid", {31'd0, QVALID}, 32'd1);
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 32'hDEAD_BEEF;
    check("t6a_q", Q, exp);
    sb.push_back(32'h000B_0000);
    @(negedge clk);
    start = 1'b0;
    check("t6_qvalid_drop", {31'd0, QVALID}, 32'd0);
    check("t6_b2b_busy", {31'd0, busy}, 32'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("t6b_busy_cycles", cnt, 32'd16);
    check("t6b_qvalid", {31'd0, QVALID}, 32'd1);
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 32'hDEAD_BEEF;
    check("t6b_q", Q, exp);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
